// File: rtl/dcache_pkg.sv
// dcache_pkg -- shared types and constants for the direct-mapped data cache
// controller.
//   state_e          : controller FSM states
//   TAG_W / IDX_W    : default tag and index widths (32 lines of 32 bytes)
//   LINE_W / WORD_W  : cache line and CPU word widths
//   *_LSB constants  : bit positions of the address fields
package dcache_pkg;

  localparam int TAG_W    = 22;
  localparam int IDX_W    = 5;
  localparam int LINE_W   = 256;
  localparam int WORD_W   = 32;
  localparam int WSEL_W   = 3;   // word select inside a line
  localparam int OFF_W    = 5;   // byte offset inside a line

  localparam int WORD_LSB = 2;
  localparam int IDX_LSB  = OFF_W;
  localparam int TAG_LSB  = OFF_W + IDX_W;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WRITEBACK   = 2'd1,
    S_ALLOCATE    = 2'd2,
    S_REFILL_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_word_merge.sv
// dcache_word_merge -- combinational insert of one 32-bit word into a line.
//   line_i : original cache line
//   sel_i  : word position within the line
//   word_i : word to insert
//   line_o : line with the selected word replaced
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [WSEL_W-1:0] sel_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [LINE_W-1:0] line_o
);

  for (genvar gi = 0; gi < LINE_W / WORD_W; gi++) begin : g_word
    assign line_o[gi*WORD_W +: WORD_W] =
      (sel_i == WSEL_W'(gi)) ? word_i : line_i[gi*WORD_W +: WORD_W];
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl -- write-back, write-allocate, direct-mapped data cache
// controller. The tag/data SRAM lives outside; it is read combinationally
// at the index of cpu_addr_i and written on the clock edge when sram_we_o=1.
//   clk_i, rst_i                : clock, asynchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i, cpu_rdata_o, stall_o : CPU side
//   sram_*_i                    : SRAM entry at the current index
//   sram_we_o, sram_*_o         : SRAM write port (same index)
//   mem_enable_o/write_o/addr_o/data_o, mem_data_i, mem_ack_i : line memory
//   hit_cnt_o, miss_cnt_o       : only when DCACHE_PERF_CNT_EN is defined
// Optional feature macro: DCACHE_PERF_CNT_EN (saturating hit/miss counters).
module dcache_ctrl #(
  parameter int TAG_W = dcache_pkg::TAG_W,
  parameter int IDX_W = dcache_pkg::IDX_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cpu_req_i,
  input  logic                          cpu_we_i,
  input  logic [31:0]                   cpu_addr_i,
  input  logic [31:0]                   cpu_wdata_i,
  output logic [31:0]                   cpu_rdata_o,
  output logic                          stall_o,
  input  logic                          sram_valid_i,
  input  logic                          sram_dirty_i,
  input  logic [TAG_W-1:0]              sram_tag_i,
  input  logic [dcache_pkg::LINE_W-1:0] sram_line_i,
  output logic                          sram_we_o,
  output logic                          sram_valid_o,
  output logic                          sram_dirty_o,
  output logic [TAG_W-1:0]              sram_tag_o,
  output logic [dcache_pkg::LINE_W-1:0] sram_line_o,
  output logic                          mem_enable_o,
  output logic                          mem_write_o,
  output logic [31:0]                   mem_addr_o,
  output logic [dcache_pkg::LINE_W-1:0] mem_data_o,
  input  logic [dcache_pkg::LINE_W-1:0] mem_data_i,
  input  logic                          mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]                   hit_cnt_o,
  output logic [31:0]                   miss_cnt_o
`endif
);
  import dcache_pkg::*;

  // Address fields; the low two bits select a byte and are not used.
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] wsel;
  logic [1:0]        unused_byte_off;

  assign tag             = cpu_addr_i[31 -: TAG_W];
  assign idx             = cpu_addr_i[OFF_W +: IDX_W];
  assign wsel            = cpu_addr_i[WORD_LSB +: WSEL_W];
  assign unused_byte_off = cpu_addr_i[1:0];

  state_e state_q;
  logic   hit;
  logic   in_idle;
  logic   [LINE_W-1:0] merged_line;

  assign in_idle = (state_q == S_IDLE);
  assign hit     = cpu_req_i & sram_valid_i & (sram_tag_i == tag);

  dcache_word_merge u_merge (
    .line_i (sram_line_i),
    .sel_i  (wsel),
    .word_i (cpu_wdata_i),
    .line_o (merged_line)
  );

  // ---------------------------------------------------------------------
  // CPU side: loads hit with zero added latency; a miss stalls in the same
  // cycle it is presented.
  // ---------------------------------------------------------------------
  assign cpu_rdata_o = sram_line_i[{wsel, 5'b0} +: WORD_W];
  assign stall_o     = !in_idle | (cpu_req_i & !hit);

  // ---------------------------------------------------------------------
  // Memory side: address comes from the victim tag during writeback and
  // from the requested tag during allocation.
  // ---------------------------------------------------------------------
  assign mem_enable_o = (state_q == S_WRITEBACK) | (state_q == S_ALLOCATE);
  assign mem_write_o  = (state_q == S_WRITEBACK);
  assign mem_addr_o   = (state_q == S_WRITEBACK) ? {sram_tag_i, idx, 5'b0}
                                                 : {tag, idx, 5'b0};
  assign mem_data_o   = sram_line_i;

  // ---------------------------------------------------------------------
  // SRAM write port: store hit merges a word and marks the line dirty; a
  // refill writes the fetched line clean under the new tag.
  // ---------------------------------------------------------------------
  always_comb begin
    sram_we_o    = 1'b0;
    sram_valid_o = 1'b1;
    sram_dirty_o = 1'b1;
    sram_tag_o   = sram_tag_i;
    sram_line_o  = merged_line;
    if (in_idle) begin
      // Reset forces IDLE, so the store-hit path is the only write that
      // needs explicit gating while rst_i is high.
      sram_we_o = hit & cpu_we_i & !rst_i;
    end else if (state_q == S_ALLOCATE && mem_ack_i) begin
      sram_we_o    = 1'b1;
      sram_dirty_o = 1'b0;
      sram_tag_o   = tag;
      sram_line_o  = mem_data_i;
    end
  end

  // ---------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_req_i && !hit) begin
            state_q <= (sram_valid_i && sram_dirty_i) ? S_WRITEBACK : S_ALLOCATE;
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) state_q <= S_ALLOCATE;
        end
        S_ALLOCATE: begin
          if (mem_ack_i) state_q <= S_REFILL_DONE;
        end
        default: state_q <= S_IDLE;   // REFILL_DONE lasts one cycle
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // The replayed access right after a refill hits by construction and is
  // already accounted for as a miss, so it is excluded from the hit count.
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        after_refill_q;
  logic        count_hit, count_miss;

  assign count_hit  = in_idle & hit & !after_refill_q;
  assign count_miss = in_idle & cpu_req_i & !hit;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (count_hit && hit_cnt_q != '1)   hit_cnt_d  = hit_cnt_q + 32'd1;
    if (count_miss && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
      after_refill_q <= 1'b0;
    end else begin
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      after_refill_q <= (state_q == S_REFILL_DONE);
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
